// File: rtl/sccb_target.sv
// rtl/sccb_target.sv - SCCB 2-wire target with 256x8 register file
// Open-drain SIO_D: driven low or released, bus pull-up is external.
module sccb_target #(
  parameter logic [7:0] DEV_ID      = 8'h60,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       XCLK,
  input  logic       RST,
  input  logic       SIO_C,
  inout  wire        SIO_D,
  input  logic [7:0] dbg_addr,
  output logic [7:0] dbg_data,
  output logic       wr_strobe,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       rd_strobe,
  output logic       busy
);

  typedef enum logic [3:0] {
    S_IDLE, S_ID, S_ID_DC, S_SUB, S_SUB_DC, S_WR, S_WR_DC, S_RD, S_RD_NA, S_WAIT_STOP
  } state_t;

  logic [SYNC_STAGES-1:0] c_sync_q, d_sync_q;
  logic                   c_prev_q, d_prev_q;
  logic                   scl, sda, scl_rise, scl_fall, bus_start, bus_stop;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] addr_ptr_q, addr_ptr_d;
  logic       rw_q, rw_d;
  logic       oe_q, oe_d;
  logic       busy_q, busy_d;
  logic       wr_strobe_q, wr_strobe_d;
  logic [7:0] wr_addr_q, wr_addr_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic       rd_strobe_q, rd_strobe_d;
  logic [7:0] dbg_data_q;
  logic       reg_we;
  logic [7:0] regs_q [256];

  assign SIO_D = oe_q ? 1'b0 : 1'bz;

  assign scl       = c_sync_q[SYNC_STAGES-1];
  assign sda       = d_sync_q[SYNC_STAGES-1];
  assign scl_rise  = scl & ~c_prev_q;
  assign scl_fall  = ~scl & c_prev_q;
  assign bus_start = scl & d_prev_q & ~sda;
  assign bus_stop  = scl & ~d_prev_q & sda;

  // Synchronizers reset to the idle-bus level so reset never fakes a START.
  always_ff @(posedge XCLK) begin
    if (RST) begin
      c_sync_q <= '1;
      d_sync_q <= '1;
      c_prev_q <= 1'b1;
      d_prev_q <= 1'b1;
    end else begin
      c_sync_q <= {c_sync_q[SYNC_STAGES-2:0], SIO_C};
      d_sync_q <= {d_sync_q[SYNC_STAGES-2:0], SIO_D};
      c_prev_q <= scl;
      d_prev_q <= sda;
    end
  end

  always_ff @(posedge XCLK) begin
    if (RST) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      shift_q     <= 8'h00;
      addr_ptr_q  <= 8'h00;
      rw_q        <= 1'b0;
      oe_q        <= 1'b0;
      busy_q      <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= 8'h00;
      wr_data_q   <= 8'h00;
      rd_strobe_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      addr_ptr_q  <= addr_ptr_d;
      rw_q        <= rw_d;
      oe_q        <= oe_d;
      busy_q      <= busy_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      rd_strobe_q <= rd_strobe_d;
    end
  end

  always_ff @(posedge XCLK) begin
    if (RST) begin
      for (int i = 0; i < 256; i++) regs_q[i] <= 8'h00;
      dbg_data_q <= 8'h00;
    end else begin
      if (reg_we) regs_q[addr_ptr_q] <= shift_d;
      dbg_data_q <= regs_q[dbg_addr];
    end
  end

  // DC states: cnt_q==0 until the 9th rise; first fall drives low, second ends the phase.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    addr_ptr_d  = addr_ptr_q;
    rw_d        = rw_q;
    oe_d        = oe_q;
    busy_d      = busy_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    rd_strobe_d = 1'b0;
    reg_we      = 1'b0;

    if (bus_stop) begin
      state_d = S_IDLE;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
    end else if (bus_start) begin
      state_d = S_ID;
      cnt_d   = 4'd0;
      shift_d = 8'h00;
      oe_d    = 1'b0;
    end else begin
      case (state_q)
        S_ID: begin
          if (scl_rise) begin
            shift_d = {shift_q[6:0], sda};
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              cnt_d = 4'd0;
              if (shift_d[7:1] == DEV_ID[7:1]) begin
                rw_d    = sda;
                busy_d  = 1'b1;
                state_d = S_ID_DC;
              end else begin
                busy_d  = 1'b0;
                state_d = S_WAIT_STOP;
              end
            end
          end
        end
        S_ID_DC, S_SUB_DC, S_WR_DC: begin
          if (scl_rise) begin
            cnt_d = 4'd1;
          end else if (scl_fall) begin
            if (cnt_q == 4'd0) begin
              oe_d = 1'b1;
            end else begin
              oe_d  = 1'b0;
              cnt_d = 4'd0;
              case (state_q)
                S_ID_DC: begin
                  if (rw_q) begin
                    state_d     = S_RD;
                    shift_d     = regs_q[addr_ptr_q];
                    oe_d        = ~regs_q[addr_ptr_q][7];
                    rd_strobe_d = 1'b1;
                  end else begin
                    state_d = S_SUB;
                  end
                end
                S_SUB_DC: state_d = S_WR;
                default:  state_d = S_WAIT_STOP;
              endcase
            end
          end
        end
        S_SUB, S_WR: begin
          if (scl_rise) begin
            shift_d = {shift_q[6:0], sda};
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              cnt_d = 4'd0;
              if (state_q == S_SUB) begin
                addr_ptr_d = shift_d;
                state_d    = S_SUB_DC;
              end else begin
                reg_we      = 1'b1;
                wr_strobe_d = 1'b1;
                wr_addr_d   = addr_ptr_q;
                wr_data_d   = shift_d;
                state_d     = S_WR_DC;
              end
            end
          end
        end
        S_RD: begin
          if (scl_rise) begin
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (cnt_q == 4'd8) begin
              oe_d    = 1'b0;
              cnt_d   = 4'd0;
              state_d = S_RD_NA;
            end else begin
              shift_d = {shift_q[6:0], 1'b0};
              oe_d    = ~shift_q[6];
            end
          end
        end
        S_RD_NA: begin
          oe_d = 1'b0;
          if (scl_rise) state_d = S_WAIT_STOP;
        end
        S_WAIT_STOP: oe_d = 1'b0;
        default:     oe_d = 1'b0;
      endcase
    end
  end

  assign dbg_data  = dbg_data_q;
  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign rd_strobe = rd_strobe_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_sccb_target.sv
// tb/tb_sccb_target.sv - directed bench for sccb_target with write scoreboard
module tb_sccb_target;

  localparam int Q = 8;

  logic       xclk = 1'b0;
  logic       rst = 1'b1;
  logic       sio_c = 1'b1;
  logic       m_low = 1'b0;
  logic [7:0] dbg_addr = 8'h00;
  logic [7:0] dbg_data;
  logic       wr_strobe, rd_strobe, busy;
  logic [7:0] wr_addr, wr_data;
  wire        sio_d;

  pullup pu (sio_d);
  assign sio_d = m_low ? 1'b0 : 1'bz;

  int compared = 0;
  int mismatched = 0;
  int rd_cnt = 0;
  int dut_low_cnt = 0;
  logic [15:0] exp_q[$];

  sccb_target #(.DEV_ID(8'h60), .SYNC_STAGES(2)) dut (
    .XCLK(xclk), .RST(rst), .SIO_C(sio_c), .SIO_D(sio_d),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data), .wr_strobe(wr_strobe),
    .wr_addr(wr_addr), .wr_data(wr_data), .rd_strobe(rd_strobe), .busy(busy)
  );

  always #10 xclk = ~xclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge xclk) begin
    if (sio_d === 1'b0 && !m_low) dut_low_cnt++;
    if (rd_strobe) rd_cnt++;
    if (wr_strobe) begin
      if (exp_q.size() == 0) check("wr_unexpected", {16'h0, wr_addr, wr_data}, 32'hFFFF_FFFF);
      else check("wr_commit", {16'h0, wr_addr, wr_data}, {16'h0, exp_q.pop_front()});
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_q(input int n);
    repeat (n * Q) @(negedge xclk);
  endtask

  task automatic bus_start();
    m_low = 1'b1; wait_q(1); sio_c = 1'b0; wait_q(1);
  endtask

  task automatic bus_rstart();
    m_low = 1'b0; wait_q(1); sio_c = 1'b1; wait_q(1);
    m_low = 1'b1; wait_q(1); sio_c = 1'b0; wait_q(1);
  endtask

  task automatic bus_stop();
    m_low = 1'b1; wait_q(1); sio_c = 1'b1; wait_q(1); m_low = 1'b0; wait_q(2);
  endtask

  task automatic send_bit(input logic b);
    m_low = ~b; wait_q(1); sio_c = 1'b1; wait_q(2); sio_c = 1'b0; wait_q(1);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    m_low = 1'b0; wait_q(1); sio_c = 1'b1; wait_q(1);
    ack = (sio_d === 1'b0) ? 1'b0 : 1'b1;
    wait_q(1); sio_c = 1'b0; wait_q(1);
  endtask

  task automatic recv_byte(output logic [7:0] b);
    m_low = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      wait_q(1); sio_c = 1'b1; wait_q(1);
      b[i] = (sio_d === 1'b0) ? 1'b0 : 1'b1;
      wait_q(1); sio_c = 1'b0; wait_q(1);
    end
    m_low = 1'b0; wait_q(1); sio_c = 1'b1; wait_q(2); sio_c = 1'b0; wait_q(1);
  endtask

  task automatic dbg_read(input string tag, input logic [7:0] a, input logic [7:0] exp);
    dbg_addr = a;
    @(negedge xclk);
    check(tag, {24'h0, dbg_data}, {24'h0, exp});
  endtask

  initial begin
    logic       ack;
    logic [7:0] rb;

    repeat (4) @(negedge xclk);
    rst = 1'b0;
    @(negedge xclk);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_strobes", {30'h0, wr_strobe, rd_strobe}, 32'h0);
    check("rst_wr_addr_data", {16'h0, wr_addr, wr_data}, 32'h0);
    check("rst_dbg_data", {24'h0, dbg_data}, 32'h0);
    check("rst_sio_d", {31'h0, sio_d}, 32'h1);

    // 3-phase write 0x60 / 0x12 / 0xA5
    bus_start();
    send_byte(8'h60, ack); check("w3_ack_id", {31'h0, ack}, 32'h0);
    check("w3_busy", {31'h0, busy}, 32'h1);
    send_byte(8'h12, ack); check("w3_ack_sub", {31'h0, ack}, 32'h0);
    exp_q.push_back({8'h12, 8'hA5});
    send_byte(8'hA5, ack); check("w3_ack_data", {31'h0, ack}, 32'h0);
    bus_stop();
    check("w3_busy_after", {31'h0, busy}, 32'h0);
    dbg_read("w3_dbg_12", 8'h12, 8'hA5);

    // 2-phase write sets pointer, then 2-phase read
    bus_start();
    send_byte(8'h60, ack); check("rb_ack_id", {31'h0, ack}, 32'h0);
    send_byte(8'h12, ack); check("rb_ack_sub", {31'h0, ack}, 32'h0);
    bus_stop();
    rd_cnt = 0;
    bus_start();
    send_byte(8'h61, ack); check("rb_ack_rid", {31'h0, ack}, 32'h0);
    recv_byte(rb);
    check("rb_data", {24'h0, rb}, 32'hA5);
    bus_stop();
    check("rb_rd_strobe_cnt", rd_cnt, 1);
    check("rb_sio_d_idle", {31'h0, sio_d}, 32'h1);
    check("rb_busy_after", {31'h0, busy}, 32'h0);

    // Wrong device ID is never acknowledged or committed
    dut_low_cnt = 0;
    bus_start();
    send_byte(8'h42, ack); check("wid_ack_id", {31'h0, ack}, 32'h1);
    send_byte(8'h00, ack);
    send_byte(8'hFF, ack);
    bus_stop();
    check("wid_no_drive", dut_low_cnt, 0);
    check("wid_busy", {31'h0, busy}, 32'h0);
    dbg_read("wid_dbg_00", 8'h00, 8'h00);

    // Abort mid-data, then a valid write to 0x31
    bus_start();
    send_byte(8'h60, ack);
    send_byte(8'h30, ack);
    for (int i = 0; i < 4; i++) send_bit(i[0]);
    bus_stop();
    dbg_read("abort_dbg_30", 8'h30, 8'h00);
    bus_start();
    send_byte(8'h60, ack);
    send_byte(8'h31, ack);
    exp_q.push_back({8'h31, 8'h77});
    send_byte(8'h77, ack); check("abort_next_ack", {31'h0, ack}, 32'h0);
    bus_stop();
    dbg_read("abort_dbg_31", 8'h31, 8'h77);

    // Repeated START in the middle of the ID byte
    bus_start();
    for (int i = 0; i < 4; i++) send_bit(i == 1 || i == 2);
    bus_rstart();
    send_byte(8'h60, ack); check("rs_ack_id", {31'h0, ack}, 32'h0);
    send_byte(8'h05, ack);
    exp_q.push_back({8'h05, 8'h3C});
    send_byte(8'h3C, ack);
    bus_stop();
    dbg_read("rs_dbg_05", 8'h05, 8'h3C);

    // Reset while the target drives the ID acknowledge
    bus_start();
    for (int i = 7; i >= 0; i--) send_bit(i == 6 || i == 5);
    m_low = 1'b0;
    wait_q(1);
    check("rst_mid_dc_low", {31'h0, sio_d}, 32'h0);
    rst = 1'b1;
    @(negedge xclk);
    rst = 1'b0;
    check("rst_mid_released", {31'h0, sio_d}, 32'h1);
    dut_low_cnt = 0;
    sio_c = 1'b1; wait_q(2); sio_c = 1'b0; wait_q(1);
    send_byte(8'h05, ack);
    send_byte(8'h99, ack);
    bus_stop();
    check("rst_mid_ignored", dut_low_cnt, 0);
    check("rst_mid_busy", {31'h0, busy}, 32'h0);
    dbg_read("rst_dbg_12", 8'h12, 8'h00);
    dbg_read("rst_dbg_05", 8'h05, 8'h00);
    dbg_read("rst_dbg_31", 8'h31, 8'h00);

    repeat (4) @(negedge xclk);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
